// File: rtl/code_loader_if.sv
// Byte-stream input and code-memory write bus of the code loader.
// The master modport is the loader side; slave is the host/memory side.
interface code_loader_if #(
    parameter int unsigned ADDR_W = 9
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              code_w_en;
    logic [ADDR_W-1:0] code_addr_in;
    logic [15:0]       code_in;

    modport master (
        input  in_data,
        input  in_valid,
        output in_ready,
        output code_w_en,
        output code_addr_in,
        output code_in
    );

    modport slave (
        output in_data,
        output in_valid,
        input  in_ready,
        input  code_w_en,
        input  code_addr_in,
        input  code_in
    );
endinterface

// File: rtl/code_loader.sv
// Boot sequencer: loads a length-prefixed byte stream into code memory, then raises run.
// Defining CODE_LOADER_CSUM_EN adds a trailing XOR checksum byte and the error flag.
module code_loader #(
    parameter int unsigned ADDR_W    = 9,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_start,
    input  logic          halt,
    code_loader_if.master bus,
    output logic          run,
    output logic          busy,
    output logic          done,
    output logic          error
);

    typedef enum logic [3:0] {
        StIdle,
        StLenHi,
        StLenLo,
        StDataHi,
        StDataLo,
        StWrite,
        StCsum,
        StRun,
        StError
    } state_e;

    localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);

    state_e            state_q;
    logic [7:0]        byte_hi_q;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       word_q;
    logic              done_q;
    logic              accept;
    logic [15:0]       len_raw;

`ifdef CODE_LOADER_CSUM_EN
    logic [7:0] csum_q;
    logic       error_q;
    logic       start_load;
`endif

    assign accept  = bus.in_valid & bus.in_ready;
    assign len_raw = {byte_hi_q, bus.in_data};

    // in_ready depends on state only, never on in_valid
    assign bus.in_ready = state_q inside {StLenHi, StLenLo, StDataHi, StDataLo, StCsum};
    // halt drops a pending write in the same cycle it is raised
    assign bus.code_w_en    = (state_q == StWrite) & ~halt;
    assign bus.code_addr_in = addr_q;
    assign bus.code_in      = word_q;

    assign run  = (state_q == StRun);
    assign busy = state_q inside {StLenHi, StLenLo, StDataHi, StDataLo, StWrite, StCsum};
    assign done = done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            byte_hi_q <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            addr_q    <= '0;
            word_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (halt) begin
                state_q <= StIdle;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (load_start) state_q <= StLenHi;
                    end
                    StLenHi: begin
                        if (accept) begin
                            byte_hi_q <= bus.in_data;
                            state_q   <= StLenLo;
                        end
                    end
                    StLenLo: begin
                        if (accept) begin
                            len_q   <= len_raw[ADDR_W-1:0];
                            idx_q   <= '0;
                            state_q <= StDataHi;
                        end
                    end
                    StDataHi: begin
                        if (accept) begin
                            byte_hi_q <= bus.in_data;
                            state_q   <= StDataLo;
                        end
                    end
                    StDataLo: begin
                        if (accept) begin
                            word_q  <= {byte_hi_q, bus.in_data};
                            addr_q  <= BaseAddr + idx_q;
                            state_q <= StWrite;
                        end
                    end
                    StWrite: begin
                        if (idx_q == len_q) begin
`ifdef CODE_LOADER_CSUM_EN
                            state_q <= StCsum;
`else
                            state_q <= StRun;
                            done_q  <= 1'b1;
`endif
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= StDataHi;
                        end
                    end
                    StCsum: begin
`ifdef CODE_LOADER_CSUM_EN
                        if (accept) begin
                            if (bus.in_data == csum_q) begin
                                state_q <= StRun;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= StError;
                            end
                        end
`else
                        state_q <= StIdle;
`endif
                    end
                    StRun, StError: begin
                        if (load_start) state_q <= StLenHi;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

`ifdef CODE_LOADER_CSUM_EN
    assign start_load = ~halt & load_start & (state_q inside {StIdle, StRun, StError});

    // Running XOR over every accepted byte before the checksum byte itself
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum_q  <= '0;
            error_q <= 1'b0;
        end else if (start_load) begin
            csum_q  <= '0;
            error_q <= 1'b0;
        end else if (!halt && accept) begin
            if (state_q == StCsum) begin
                if (bus.in_data != csum_q) error_q <= 1'b1;
            end else begin
                csum_q <= csum_q ^ bus.in_data;
            end
        end
    end

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_code_loader.sv
// Self-checking bench for code_loader: two instances (base 0 and base 510) share one stream
// and are checked against a byte-stream reference model.
module tb_code_loader;
    localparam int unsigned AW    = 9;
    localparam int unsigned BASE0 = 0;
    localparam int unsigned BASE1 = 510;
    localparam int unsigned MSIZE = 512;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_start;
    logic       halt;
    logic [7:0] in_data;
    logic       in_valid;
    logic       run0, busy0, done0, err0;
    logic       run1, busy1, done1, err1;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]  stream[$];
    logic [31:0] wr0[$], wr1[$], exp0[$], exp1[$];
    int cyc       = 0;
    int done0_cnt = 0;
    int done1_cnt = 0;
    int rise0     = -1;
    int wen0_last = -1;
    logic run0_prev = 1'b0;

    code_loader_if #(.ADDR_W(AW)) bus0 ();
    code_loader_if #(.ADDR_W(AW)) bus1 ();

    assign bus0.in_data  = in_data;
    assign bus0.in_valid = in_valid;
    assign bus1.in_data  = in_data;
    assign bus1.in_valid = in_valid;

    code_loader #(.ADDR_W(AW), .BASE_ADDR(BASE0)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .halt       (halt),
        .bus        (bus0),
        .run        (run0),
        .busy       (busy0),
        .done       (done0),
        .error      (err0)
    );

    code_loader #(.ADDR_W(AW), .BASE_ADDR(BASE1)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .halt       (halt),
        .bus        (bus1),
        .run        (run1),
        .busy       (busy1),
        .done       (done1),
        .error      (err1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor samples 1 time unit after each falling edge
    initial begin
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            if (bus0.code_w_en === 1'b1) begin
                wr0.push_back({7'd0, bus0.code_addr_in, bus0.code_in});
                wen0_last = cyc;
                chk("wen_with_run", 32'(run0), 0);
                chk("wen_with_ready", 32'(bus0.in_ready), 0);
            end
            if (bus1.code_w_en === 1'b1) wr1.push_back({7'd0, bus1.code_addr_in, bus1.code_in});
            if (run0 === 1'b1 && run0_prev !== 1'b1) rise0 = cyc;
            if (done0 === 1'b1) done0_cnt++;
            if (done1 === 1'b1) done1_cnt++;
            run0_prev = run0;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // Reference: len+1 words, big-endian pairs, address (base+i) mod memory size
    task automatic build_expect();
        int unsigned len;
        logic [8:0]  a;
        exp0.delete();
        exp1.delete();
        len = {stream[0], stream[1]} % MSIZE;
        for (int i = 0; i <= int'(len); i++) begin
            a = 9'((BASE0 + i) % MSIZE);
            exp0.push_back({7'd0, a, stream[2 + 2 * i], stream[3 + 2 * i]});
            a = 9'((BASE1 + i) % MSIZE);
            exp1.push_back({7'd0, a, stream[2 + 2 * i], stream[3 + 2 * i]});
        end
    endtask

    task automatic add_csum(input bit bad);
`ifdef CODE_LOADER_CSUM_EN
        logic [7:0] x = 8'h00;
        foreach (stream[i]) x ^= stream[i];
        stream.push_back(bad ? (x ^ 8'h5A) : x);
`else
        if (bad) $display("note: checksum not built in");
`endif
    endtask

    // Starts at a falling edge, ends at the falling edge after the last accept
    task automatic send(input int mode);
        int  i = 0;
        int  budget = 0;
        bit  tog = 1'b1;
        while (i < stream.size() && budget < 20000) begin
            in_data = stream[i];
            case (mode)
                0: in_valid = 1'b1;
                1: begin in_valid = tog; tog = ~tog; end
                default: begin
                    in_valid   = 1'($urandom_range(0, 1));
                    load_start = 1'($urandom_range(0, 1));
                end
            endcase
            if (in_valid && bus0.in_ready) i++;
            @(negedge clk);
            budget++;
        end
        in_valid   = 1'b0;
        load_start = 1'b0;
        if (budget >= 20000) chk("send_timeout", i, stream.size());
    endtask

    task automatic cmp_writes(input string tag, input logic [31:0] got[$],
                              input logic [31:0] exp[$]);
        chk({tag, "_count"}, got.size(), exp.size());
        for (int i = 0; i < got.size() && i < exp.size(); i++)
            chk($sformatf("%s_w%0d", tag, i), got[i], exp[i]);
    endtask

    task automatic do_load(input int mode, input bit ok);
        build_expect();
        wr0.delete();
        wr1.delete();
        done0_cnt = 0;
        done1_cnt = 0;
        rise0     = -1;
        wen0_last = -1;
        @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        chk("start_run_low", 32'(run0), 0);
        chk("start_busy", 32'(busy0), 1);
        send(mode);
        for (int k = 0; k < 12 && run0 !== 1'b1 && err0 !== 1'b1; k++) @(negedge clk);
        #2;
        chk("end_run0", 32'(run0), 32'(ok));
        chk("end_run1", 32'(run1), 32'(ok));
        chk("end_error", 32'(err0), 32'(!ok));
        chk("end_busy", 32'(busy0), 0);
        chk("done0_pulses", done0_cnt, 32'(ok));
        chk("done1_pulses", done1_cnt, 32'(ok));
        if (ok) begin
`ifdef CODE_LOADER_CSUM_EN
            if (mode == 0) chk("run_rise", rise0, wen0_last + 2);
`else
            chk("run_rise", rise0, wen0_last + 1);
`endif
        end
        cmp_writes("dut0", wr0, exp0);
        cmp_writes("dut1", wr1, exp1);
    endtask

    task automatic rand_stream(input logic [7:0] hi, input logic [7:0] lo);
        int unsigned n;
        stream.delete();
        stream.push_back(hi);
        stream.push_back(lo);
        n = ({hi, lo} % MSIZE) + 1;
        for (int i = 0; i < int'(2 * n); i++) stream.push_back(8'($urandom));
    endtask

    initial begin
        bit bad;
        rst        = 1'b1;
        load_start = 1'b0;
        halt       = 1'b0;
        in_valid   = 1'b1;
        in_data    = 8'hA5;

        // Reset with in_valid high
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", 32'(bus0.in_ready), 0);
        chk("rst_wen", 32'(bus0.code_w_en), 0);
        chk("rst_addr", 32'(bus0.code_addr_in), 0);
        chk("rst_code", 32'(bus0.code_in), 0);
        chk("rst_run", 32'(run0), 0);
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_done", 32'(done0), 0);
        chk("rst_error", 32'(err0), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("idle_ready", 32'(bus0.in_ready), 0);
        chk("idle_busy", 32'(busy0), 0);
        chk("idle_writes", wr0.size(), 0);
        in_valid = 1'b0;

        // Directed 3-word load, held valid then toggling valid
        stream = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'hFF};
        add_csum(1'b0);
        do_load(0, 1'b1);
        if (wr0.size() == 3) begin
            chk("w0_lit", wr0[0], 32'h0000_1234);
            chk("w1_lit", wr0[1], 32'h0001_ABCD);
            chk("w2_lit", wr0[2], 32'h0002_00FF);
        end
        do_load(1, 1'b1);

        // Halt while the second word's write is pending
        stream = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        wr0.delete();
        done0_cnt = 0;
        @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        send(0);
        halt = 1'b1;
        #2;
        chk("halt_wen_masked", 32'(bus0.code_w_en), 0);
        @(negedge clk);
        halt = 1'b0;
        #2;
        chk("halt_busy", 32'(busy0), 0);
        chk("halt_run", 32'(run0), 0);
        chk("halt_ready", 32'(bus0.in_ready), 0);
        chk("halt_writes", wr0.size(), 1);
        chk("halt_done", done0_cnt, 0);

        // Wrap: dut1 base 510, len 3 -> 510, 511, 0, 1
        rand_stream(8'h00, 8'h03);
        add_csum(1'b0);
        do_load(0, 1'b1);
        if (wr1.size() == 4) begin
            chk("wrap_a0", 32'(wr1[0][24:16]), 510);
            chk("wrap_a1", 32'(wr1[1][24:16]), 511);
            chk("wrap_a2", 32'(wr1[2][24:16]), 0);
            chk("wrap_a3", 32'(wr1[3][24:16]), 1);
        end

`ifdef CODE_LOADER_CSUM_EN
        stream = '{8'h00, 8'h00, 8'h12, 8'h34, 8'h26};
        do_load(0, 1'b1);
        stream = '{8'h00, 8'h00, 8'h12, 8'h34, 8'h27};
        do_load(0, 1'b0);
        @(negedge clk);
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        #1;
        chk("err_after_halt", 32'(err0), 1);
        chk("err_halt_busy", 32'(busy0), 0);
        do_load(0, 1'b0);
        stream = '{8'h00, 8'h00, 8'h12, 8'h34, 8'h26};
        do_load(0, 1'b1);
`endif

        // Randomised loads; even LEN_HI values exercise ignored upper length bits
        for (int t = 0; t < 8; t++) begin
            rand_stream(8'($urandom) & 8'hFE, 8'($urandom_range(0, 7)));
            bad = ($urandom_range(0, 3) == 0);
`ifdef CODE_LOADER_CSUM_EN
            add_csum(bad);
`else
            bad = 1'b0;
`endif
            do_load(int'($urandom_range(0, 2)), !bad);
        end

        // Full-memory image
        rand_stream(8'hFF, 8'hFF);
        add_csum(1'b0);
        do_load(0, 1'b1);

        // Reset mid-load keeps the partial image and clears all outputs
        stream = '{8'h00, 8'h01, 8'hAA, 8'hBB};
        wr0.delete();
        @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        send(0);
        #2;
        rst = 1'b1;
        #1;
        chk("mrst_busy", 32'(busy0), 0);
        chk("mrst_ready", 32'(bus0.in_ready), 0);
        chk("mrst_wen", 32'(bus0.code_w_en), 0);
        chk("mrst_addr", 32'(bus0.code_addr_in), 0);
        chk("mrst_code", 32'(bus0.code_in), 0);
        chk("mrst_run", 32'(run0), 0);
        chk("mrst_writes", wr0.size(), 1);
        @(negedge clk);
        rst = 1'b0;
        rand_stream(8'h00, 8'h02);
        add_csum(1'b0);
        do_load(2, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
